// File: rtl/iir_pkg.sv
// Shared definitions for the time-multiplexed biquad: coefficient indices,
// the coefficient bank type and the round/saturate helper.
package iir_pkg;

   localparam int IIR_DW = 11;
   localparam int IIR_CW = 12;
   localparam int NCOEF  = 5;

   localparam int B0 = 0;
   localparam int B1 = 1;
   localparam int B2 = 2;
   localparam int A1 = 3;
   localparam int A2 = 4;

   typedef logic signed [IIR_CW-1:0] coef_bank_t [NCOEF];

   typedef struct packed {
      logic               sat;
      logic signed [31:0] y;
   } sr_t;

   // Width-agnostic: acc arrives sign-extended to 64 bits, widths as arguments.
   function automatic sr_t sat_round(input longint acc, input int dw, input int cw);
      longint r;
      longint hi;
      longint lo;
      sr_t    o;
      r     = (acc + (longint'(1) <<< (cw - 3))) >>> (cw - 2);
      hi    = (longint'(1) <<< (dw - 1)) - 1;
      lo    = -hi - 1;
      o.sat = 1'b0;
      o.y   = 32'(r);
      if (r > hi) begin
         o.y   = 32'(hi);
         o.sat = 1'b1;
      end else if (r < lo) begin
         o.y   = 32'(lo);
         o.sat = 1'b1;
      end
      return o;
   endfunction

endpackage

// File: rtl/iir_biquad_tdm_mac5.sv
// Combinational Direct-Form-I five-term multiply-accumulate followed by
// half-up rounding and saturation back to the sample format.
module iir_mac5
   import iir_pkg::*;
#(
   parameter int DW = IIR_DW,
   parameter int CW = IIR_CW
) (
   input  logic signed [DW-1:0] x,
   input  logic signed [DW-1:0] x1,
   input  logic signed [DW-1:0] x2,
   input  logic signed [DW-1:0] y1,
   input  logic signed [DW-1:0] y2,
   input  logic signed [CW-1:0] b0,
   input  logic signed [CW-1:0] b1,
   input  logic signed [CW-1:0] b2,
   input  logic signed [CW-1:0] a1,
   input  logic signed [CW-1:0] a2,
   output logic signed [DW-1:0] y,
   output logic                 sat
);

   // Three guard bits cover the sum of five full-precision products.
   localparam int AW = DW + CW + 3;

   logic signed [AW-1:0] acc;
   sr_t                  r;
   logic                 unused_hi;

   always_comb begin
      acc = AW'(b0) * AW'(x)  + AW'(b1) * AW'(x1) + AW'(b2) * AW'(x2)
          - AW'(a1) * AW'(y1) - AW'(a2) * AW'(y2);
      r   = sat_round(longint'(acc), DW, CW);
      y   = r.y[DW-1:0];
      sat = r.sat;
   end

   assign unused_hi = ^r.y[31:DW];

endmodule

// File: rtl/iir_biquad_tdm.sv
// One biquad datapath shared by NCH channels: per-channel history, shared
// run-time coefficients and a one-deep valid/ready output register.
module iir_biquad_tdm
   import iir_pkg::*;
#(
   parameter  int DW  = IIR_DW,
   parameter  int CW  = IIR_CW,
   parameter  int NCH = 4,
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [DW-1:0] x,
   input  logic [CHW-1:0]       in_ch,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic signed [DW-1:0] y,
   output logic [CHW-1:0]       out_ch,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 sat,
   input  logic                 coef_we,
   input  logic [2:0]           coef_addr,
   input  logic signed [CW-1:0] coef_data,
   input  logic                 ch_clr,
   input  logic [CHW-1:0]       clr_ch
);

   logic signed [DW-1:0] x1 [NCH];
   logic signed [DW-1:0] x2 [NCH];
   logic signed [DW-1:0] y1 [NCH];
   logic signed [DW-1:0] y2 [NCH];
   logic signed [CW-1:0] coef [NCOEF];

   logic signed [DW-1:0] y_nxt;
   logic                 sat_nxt;
   logic                 accept;
   logic                 ch_ok;
   logic                 clr_ok;

   assign in_ready = (out_ready || !out_valid) && !ch_clr;
   assign accept   = in_valid && in_ready;
   assign ch_ok    = 32'(in_ch) < NCH;
   assign clr_ok   = 32'(clr_ch) < NCH;

   iir_mac5 #(.DW(DW), .CW(CW)) u_mac (
      .x   (x),
      .x1  (x1[in_ch]),
      .x2  (x2[in_ch]),
      .y1  (y1[in_ch]),
      .y2  (y2[in_ch]),
      .b0  (coef[B0]),
      .b1  (coef[B1]),
      .b2  (coef[B2]),
      .a1  (coef[A1]),
      .a2  (coef[A2]),
      .y   (y_nxt),
      .sat (sat_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         y         <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         sat       <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            x1[i] <= '0;
            x2[i] <= '0;
            y1[i] <= '0;
            y2[i] <= '0;
         end
         for (int k = 0; k < NCOEF; k++) coef[k] <= '0;
      end else begin
         // A sample accepted this cycle still sees the old coefficient.
         if (coef_we && coef_addr < 3'(NCOEF)) coef[coef_addr] <= coef_data;

         if (accept && ch_ok) begin
            y             <= y_nxt;
            sat           <= sat_nxt;
            out_ch        <= in_ch;
            out_valid     <= 1'b1;
            x2[in_ch]     <= x1[in_ch];
            x1[in_ch]     <= x;
            y2[in_ch]     <= y1[in_ch];
            y1[in_ch]     <= y_nxt;
         end else if (out_ready || !out_valid) begin
            out_valid <= 1'b0;
         end

         // ch_clr holds off accept, so it never races a history update.
         if (ch_clr && clr_ok) begin
            x1[clr_ch] <= '0;
            x2[clr_ch] <= '0;
            y1[clr_ch] <= '0;
            y2[clr_ch] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Self-checking bench for iir_biquad_tdm: directed scenarios plus a random
// run against an integer-arithmetic reference of the filter equation.
module tb_iir_biquad_tdm;

   localparam int DW  = 11;
   localparam int CW  = 12;
   localparam int NCH = 4;
   localparam int CHW = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic signed [DW-1:0] x;
   logic [CHW-1:0]       in_ch;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] y;
   logic [CHW-1:0]       out_ch;
   logic                 out_valid;
   logic                 out_ready;
   logic                 sat;
   logic                 coef_we;
   logic [2:0]           coef_addr;
   logic signed [CW-1:0] coef_data;
   logic                 ch_clr;
   logic [CHW-1:0]       clr_ch;

   int nerr = 0;
   int nchk = 0;

   // reference state
   int cb [5];
   int hx1 [NCH];
   int hx2 [NCH];
   int hy1 [NCH];
   int hy2 [NCH];

   iir_biquad_tdm #(.DW(DW), .CW(CW), .NCH(NCH)) dut (
      .clk       (clk),
      .rst       (rst),
      .x         (x),
      .in_ch     (in_ch),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sat       (sat),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .ch_clr    (ch_clr),
      .clr_ch    (clr_ch)
   );

   always #5 clk = ~clk;

   // y = clip(floor((acc + 512) / 1024)), acc from the difference equation
   function automatic void model(input int ch, input int xv, output int ey, output bit es);
      int acc;
      int q;
      int r;
      acc = cb[0] * xv + cb[1] * hx1[ch] + cb[2] * hx2[ch]
          - cb[3] * hy1[ch] - cb[4] * hy2[ch];
      q   = acc + 512;
      r   = (q >= 0) ? q / 1024 : -((-q + 1023) / 1024);
      es  = 1'b0;
      if (r > 1023) begin
         r  = 1023;
         es = 1'b1;
      end else if (r < -1024) begin
         r  = -1024;
         es = 1'b1;
      end
      hx2[ch] = hx1[ch];
      hx1[ch] = xv;
      hy2[ch] = hy1[ch];
      hy1[ch] = r;
      ey      = r;
   endfunction

   function automatic void model_clear(input int ch);
      hx1[ch] = 0;
      hx2[ch] = 0;
      hy1[ch] = 0;
      hy2[ch] = 0;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cb[i] = 0;
      for (int c = 0; c < NCH; c++) model_clear(c);
   endtask

   task automatic set_coef(input int a, input int v);
      coef_we   = 1'b1;
      coef_addr = 3'(a);
      coef_data = CW'(v);
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      if (a < 5) cb[a] = v;
   endtask

   task automatic send(input int ch, input int xv);
      in_valid = 1'b1;
      in_ch    = CHW'(ch);
      x        = DW'(xv);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
      nchk++; if (int'(y) !== 0) begin nerr++; $display("FAIL reset_y: got %0d want 0", y); end
      nchk++; if (sat !== 1'b0) begin nerr++; $display("FAIL reset_sat: got %0b want 0", sat); end
      nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_passthrough();
      int ey; bit es;
      do_reset();
      set_coef(0, 1024);
      send(0, 1023); model(0, 1023, ey, es);
      nchk++; if (int'(y) !== 1023) begin nerr++; $display("FAIL pass_y: got %0d want 1023", y); end
      nchk++; if (out_ch !== 2'd0) begin nerr++; $display("FAIL pass_ch: got %0d want 0", out_ch); end
      nchk++; if (sat !== 1'b0) begin nerr++; $display("FAIL pass_sat: got %0b want 0", sat); end
      nchk++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL pass_valid: got %0b want 1", out_valid); end
      @(posedge clk); #1;
      nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL pass_idle_valid: got %0b want 0", out_valid); end
   endtask

   task automatic test_rounding();
      int ey; bit es;
      do_reset();
      set_coef(0, 512);
      send(0, 1023); model(0, 1023, ey, es);
      nchk++; if (int'(y) !== 512) begin nerr++; $display("FAIL round_pos: got %0d want 512", y); end
      send(0, -1023); model(0, -1023, ey, es);
      nchk++; if (int'(y) !== -511) begin nerr++; $display("FAIL round_neg: got %0d want -511", y); end
   endtask

   task automatic test_decay();
      int ey; bit es;
      int exp_y [6] = '{1023, 512, 256, 128, 64, 32};
      do_reset();
      set_coef(0, 1024);
      set_coef(3, -512);
      for (int i = 0; i < 6; i++) begin
         send(1, (i == 0) ? 1023 : 0); model(1, (i == 0) ? 1023 : 0, ey, es);
         nchk++; if (int'(y) !== exp_y[i] || out_ch !== 2'd1) begin
            nerr++; $display("FAIL decay_%0d: got y=%0d ch=%0d want y=%0d ch=1", i, y, out_ch, exp_y[i]);
         end
      end
   endtask

   task automatic test_saturation();
      int ey; bit es;
      do_reset();
      set_coef(0, 1536);
      send(0, 1023); model(0, 1023, ey, es);
      nchk++; if (int'(y) !== 1023 || sat !== 1'b1) begin
         nerr++; $display("FAIL sat_pos: got y=%0d sat=%0b want y=1023 sat=1", y, sat);
      end
      send(0, -1024); model(0, -1024, ey, es);
      nchk++; if (int'(y) !== -1024 || sat !== 1'b1) begin
         nerr++; $display("FAIL sat_neg: got y=%0d sat=%0b want y=-1024 sat=1", y, sat);
      end
   endtask

   task automatic test_coef_timing();
      int ey; bit es;
      do_reset();
      set_coef(0, 1024);
      // write b0 and accept a sample at the same edge
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = CW'(512);
      send(0, 1000); coef_we = 1'b0;
      model(0, 1000, ey, es); cb[0] = 512;
      nchk++; if (int'(y) !== 1000) begin nerr++; $display("FAIL coef_old: got %0d want 1000", y); end
      send(0, 1000); model(0, 1000, ey, es);
      nchk++; if (int'(y) !== 500) begin nerr++; $display("FAIL coef_new: got %0d want 500", y); end
      set_coef(5, 2047);
      send(0, 1000); model(0, 1000, ey, es);
      nchk++; if (int'(y) !== ey) begin nerr++; $display("FAIL coef_addr5: got %0d want %0d", y, ey); end
   endtask

   task automatic test_isolation();
      int ey; bit es;
      do_reset();
      set_coef(0, 1024);
      set_coef(3, -512);
      for (int i = 0; i < 4; i++) begin
         send(0, (i == 0) ? 1023 : 0); model(0, (i == 0) ? 1023 : 0, ey, es);
         nchk++; if (int'(y) !== ey || out_ch !== 2'd0) begin
            nerr++; $display("FAIL iso_ch0_%0d: got y=%0d ch=%0d want y=%0d ch=0", i, y, out_ch, ey);
         end
         send(2, 0); model(2, 0, ey, es);
         nchk++; if (int'(y) !== 0 || out_ch !== 2'd2) begin
            nerr++; $display("FAIL iso_ch2_%0d: got y=%0d ch=%0d want y=0 ch=2", i, y, out_ch);
         end
      end
   endtask

   task automatic test_backpressure();
      int ey; bit es;
      do_reset();
      set_coef(0, 1024);
      set_coef(3, -512);
      out_ready = 1'b0;
      send(0, 1023); model(0, 1023, ey, es);
      nchk++; if (int'(y) !== 1023 || out_valid !== 1'b1) begin
         nerr++; $display("FAIL bp_first: got y=%0d v=%0b want y=1023 v=1", y, out_valid);
      end
      in_valid = 1'b1; in_ch = 2'd0; x = DW'(500);
      for (int k = 0; k < 3; k++) begin
         #1;
         nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready_%0d: got %0b want 0", k, in_ready); end
         @(posedge clk); #1;
         nchk++; if (int'(y) !== 1023 || out_valid !== 1'b1 || out_ch !== 2'd0) begin
            nerr++; $display("FAIL bp_hold_%0d: got y=%0d v=%0b want y=1023 v=1", k, y, out_valid);
         end
      end
      out_ready = 1'b1;
      #1;
      nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_release: got %0b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      model(0, 500, ey, es);
      nchk++; if (int'(y) !== ey || out_valid !== 1'b1) begin
         nerr++; $display("FAIL bp_second: got y=%0d v=%0b want y=%0d v=1", y, out_valid, ey);
      end
      @(posedge clk); #1;
      nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_drain: got %0b want 0", out_valid); end
   endtask

   task automatic test_clear();
      int ey; bit es;
      do_reset();
      set_coef(0, 1024);
      set_coef(3, -512);
      send(1, 1023); model(1, 1023, ey, es);
      send(0, 1023); model(0, 1023, ey, es);
      send(1, 0);    model(1, 0, ey, es);
      send(0, 0);    model(0, 0, ey, es);
      ch_clr = 1'b1; clr_ch = 2'd1;
      in_valid = 1'b1; in_ch = 2'd0; x = '0;
      #1;
      nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL clr_ready: got %0b want 0", in_ready); end
      @(posedge clk); #1;
      ch_clr = 1'b0; in_valid = 1'b0;
      model_clear(1);
      nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL clr_noaccept: got %0b want 0", out_valid); end
      send(1, 0); model(1, 0, ey, es);
      nchk++; if (int'(y) !== 0) begin nerr++; $display("FAIL clr_ch1: got %0d want 0", y); end
      send(0, 0); model(0, 0, ey, es);
      nchk++; if (int'(y) !== 256) begin nerr++; $display("FAIL clr_ch0: got %0d want 256", y); end
   endtask

   task automatic test_random();
      int ey; bit es;
      int ch; int xv;
      do_reset();
      for (int i = 0; i < 3; i++) set_coef(i, int'($urandom_range(0, 2048)) - 1024);
      for (int i = 3; i < 5; i++) set_coef(i, int'($urandom_range(0, 800)) - 400);
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 24) == 0) begin
            ch = int'($urandom_range(0, NCH - 1));
            ch_clr = 1'b1; clr_ch = CHW'(ch);
            @(posedge clk); #1;
            ch_clr = 1'b0;
            model_clear(ch);
         end
         if ($urandom_range(0, 5) == 0) begin
            @(posedge clk); #1;
         end
         ch = int'($urandom_range(0, NCH - 1));
         xv = int'($urandom_range(0, 2047)) - 1024;
         send(ch, xv); model(ch, xv, ey, es);
         nchk++; if (int'(y) !== ey || sat !== es || int'(out_ch) !== ch || out_valid !== 1'b1) begin
            nerr++; $display("FAIL rand_%0d: got y=%0d sat=%0b ch=%0d v=%0b want y=%0d sat=%0b ch=%0d v=1",
                             n, y, sat, out_ch, out_valid, ey, es, ch);
         end
      end
   endtask

   task automatic test_reset_mid();
      int ey; bit es;
      do_reset();
      set_coef(0, 1024);
      set_coef(3, -512);
      send(0, 1023); model(0, 1023, ey, es);
      rst = 1'b1; in_valid = 1'b1; in_ch = 2'd0; x = DW'(500);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 5; i++) cb[i] = 0;
      for (int c = 0; c < NCH; c++) model_clear(c);
      nchk++; if (out_valid !== 1'b0 || int'(y) !== 0 || sat !== 1'b0) begin
         nerr++; $display("FAIL rstmid_out: got v=%0b y=%0d sat=%0b want 0 0 0", out_valid, y, sat);
      end
      send(0, 700); model(0, 700, ey, es);
      nchk++; if (int'(y) !== 0 || out_valid !== 1'b1) begin
         nerr++; $display("FAIL rstmid_coef: got y=%0d v=%0b want y=0 v=1", y, out_valid);
      end
   endtask

   initial begin
      rst = 1'b1; x = '0; in_ch = '0; in_valid = 1'b0; out_ready = 1'b1;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0; ch_clr = 1'b0; clr_ch = '0;
      @(posedge clk); #1;
      test_reset();
      test_passthrough();
      test_rounding();
      test_decay();
      test_saturation();
      test_coef_timing();
      test_isolation();
      test_backpressure();
      test_clear();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
